// File: rtl/regfile_mp.sv
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port register file with registered reads, write-first
//             bypass, optional zero register and two debug taps.
//             Optional busy scoreboard enabled by `define REGFILE_SCOREBOARD_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int DBG_IDX0 = 2,
  parameter int DBG_IDX1 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        dbg0,
  output logic [DATA_W-1:0]        dbg1,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int                c_DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_DBG0  = ADDR_W'(DBG_IDX0);
  localparam logic [ADDR_W-1:0] c_DBG1  = ADDR_W'(DBG_IDX1);

  logic [DATA_W-1:0]        r_mem [c_DEPTH];
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic                     r_rd_valid;
  logic [NUM_RD*DATA_W-1:0] w_rd_next;
  logic                     w_wr_ok;

  // Writes to the hardwired zero register are dropped here, so bypass and
  // storage both see the same qualified write.
  assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [c_DEPTH-1:0] r_busy;
  logic [c_DEPTH-1:0] w_busy_upd;
  logic [NUM_RD-1:0]  w_busy_next;
  logic [NUM_RD-1:0]  r_rd_busy;

  // Issue is applied after the write-back clear: the issuing instruction is
  // the newer producer of that register.
  always_comb begin
    w_busy_upd = r_busy;
    if (wr_en)  w_busy_upd[wr_addr]  = 1'b0;
    if (iss_en) w_busy_upd[iss_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_upd[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_rd_busy <= '0;
    end else begin
      r_busy <= w_busy_upd;
      if (rd_en) r_rd_busy <= w_busy_next;
    end
  end

  assign rd_busy = r_rd_busy;
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{iss_en, iss_addr};
  assign rd_busy     = '0;
`endif

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      assign w_ra = rd_addr[p*ADDR_W +: ADDR_W];
      assign w_rd_next[p*DATA_W +: DATA_W] =
          ((ZERO_REG != 0) && (w_ra == '0)) ? '0      :
          (w_wr_ok && (wr_addr == w_ra))    ? wr_data :
                                              r_mem[w_ra];
`ifdef REGFILE_SCOREBOARD_EN
      assign w_busy_next[p] = w_busy_upd[w_ra];
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_next;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign dbg0     = r_mem[c_DBG0];
  assign dbg1     = r_mem[c_DBG1];

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Table-driven self-checking bench for regfile_mp with an
//             expected-result queue sampled one cycle after each drive.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

`ifdef REGFILE_SCOREBOARD_EN
  localparam bit c_SB = 1'b1;
`else
  localparam bit c_SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] dbg0, dbg1;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [1:0]  rd_busy;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg0(dbg0), .dbg1(dbg1), .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        ie;
    logic [4:0]  ia;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ev;
    logic [1:0]  eb;   // busy expected when the scoreboard is built
    logic [31:0] ed0;
    logic [31:0] ed1;
  } vec_t;

  vec_t q[$];
  int   tests  = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    rst      = v.rst;
    wr_en    = v.we;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    rd_en    = v.re;
    rd_addr  = {v.a1, v.a0};
    iss_en   = v.ie;
    iss_addr = v.ia;
    q.push_back(v);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, " rd0"},   rd_data[31:0],  e.e0);
    check({tag, " rd1"},   rd_data[63:32], e.e1);
    check({tag, " valid"}, {31'd0, rd_valid}, {31'd0, e.ev});
    check({tag, " busy"},  {30'd0, rd_busy},  {30'd0, (c_SB ? e.eb : 2'b00)});
    check({tag, " dbg0"},  dbg0, e.ed0);
    check({tag, " dbg1"},  dbg1, e.ed1);
  endtask

  vec_t tbl[21];

  initial begin
    //            rst   we    wa     wd            re    a0     a1     ie    ia     e0            e1            ev    eb     ed0        ed1
    tbl[0]  = '{1'b1,1'b1,5'd3, 32'h00000077,1'b1,5'd3, 5'd3, 1'b1,5'd3, 32'h0,       32'h0,       1'b0,2'b00,32'h0,    32'h0};
    tbl[1]  = '{1'b0,1'b1,5'd31,32'h00000001,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,       32'h0,       1'b0,2'b00,32'h0,    32'h0};
    tbl[2]  = '{1'b0,1'b1,5'd5, 32'hDEADBEEF,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,       32'h0,       1'b0,2'b00,32'h0,    32'h0};
    tbl[3]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd5, 5'd31,1'b0,5'd0, 32'hDEADBEEF,32'h1,       1'b1,2'b00,32'h0,    32'h0};
    tbl[4]  = '{1'b0,1'b1,5'd7, 32'h12345678,1'b1,5'd7, 5'd7, 1'b0,5'd0, 32'h12345678,32'h12345678,1'b1,2'b00,32'h0,    32'h0};
    tbl[5]  = '{1'b0,1'b1,5'd0, 32'hFFFFFFFF,1'b1,5'd0, 5'd0, 1'b0,5'd0, 32'h0,       32'h0,       1'b1,2'b00,32'h0,    32'h0};
    tbl[6]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd0, 5'd7, 1'b0,5'd0, 32'h0,       32'h12345678,1'b1,2'b00,32'h0,    32'h0};
    tbl[7]  = '{1'b0,1'b1,5'd2, 32'h000000A5,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,       32'h12345678,1'b0,2'b00,32'hA5,   32'h0};
    tbl[8]  = '{1'b0,1'b1,5'd4, 32'h0000005A,1'b1,5'd2, 5'd4, 1'b0,5'd0, 32'hA5,      32'h5A,      1'b1,2'b00,32'hA5,   32'h5A};
    tbl[9]  = '{1'b1,1'b1,5'd3, 32'h00000077,1'b1,5'd3, 5'd3, 1'b0,5'd0, 32'h0,       32'h0,       1'b0,2'b00,32'h0,    32'h0};
    tbl[10] = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd3, 5'd5, 1'b0,5'd0, 32'h0,       32'h0,       1'b1,2'b00,32'h0,    32'h0};
    tbl[11] = '{1'b0,1'b1,5'd6, 32'h0000CAFE,1'b1,5'd6, 5'd31,1'b0,5'd0, 32'hCAFE,    32'h0,       1'b1,2'b00,32'h0,    32'h0};
    tbl[12] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd1, 5'd2, 1'b0,5'd0, 32'hCAFE,    32'h0,       1'b0,2'b00,32'h0,    32'h0};
    tbl[13] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd3, 5'd4, 1'b0,5'd0, 32'hCAFE,    32'h0,       1'b0,2'b00,32'h0,    32'h0};
    tbl[14] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd5, 5'd6, 1'b0,5'd0, 32'hCAFE,    32'h0,       1'b0,2'b00,32'h0,    32'h0};
    tbl[15] = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd9, 5'd6, 1'b1,5'd9, 32'h0,       32'hCAFE,    1'b1,2'b01,32'h0,    32'h0};
    tbl[16] = '{1'b0,1'b1,5'd9, 32'h00000099,1'b1,5'd9, 5'd9, 1'b1,5'd9, 32'h99,      32'h99,      1'b1,2'b11,32'h0,    32'h0};
    tbl[17] = '{1'b0,1'b1,5'd9, 32'h00000100,1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h99,      32'h99,      1'b0,2'b11,32'h0,    32'h0};
    tbl[18] = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd9, 5'd0, 1'b0,5'd0, 32'h100,     32'h0,       1'b1,2'b00,32'h0,    32'h0};
    tbl[19] = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd0, 5'd9, 1'b1,5'd0, 32'h0,       32'h100,     1'b1,2'b00,32'h0,    32'h0};
    tbl[20] = '{1'b0,1'b1,5'd31,32'h00000003,1'b1,5'd31,5'd5, 1'b1,5'd31,32'h3,       32'h0,       1'b1,2'b01,32'h0,    32'h0};

    @(negedge clk);
    apply(tbl[0], "reset");

    // Post-reset sweep of the whole address space on both ports.
    for (int i = 0; i < 32; i++) begin
      vec_t v;
      v = '{1'b0,1'b0,5'd0,32'h0,1'b1,5'(i),5'(31-i),1'b0,5'd0,
            32'h0,32'h0,1'b1,2'b00,32'h0,32'h0};
      apply(v, $sformatf("sweep%0d", i));
    end

    for (int k = 1; k < 21; k++) apply(tbl[k], $sformatf("vec%0d", k));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the CPU's register file: 2^ADDR_W x DATA_W storage, NUM_RD registered read ports, one write port.
- Synchronous reset clears all storage. Write-to-read bypass within the same edge. Optional hardwired zero register. Two debug taps for bench visibility.
- Sits in the decode stage: read addresses come from IF/ID, write port is driven from WB.
- Optional per-register busy scoreboard supports hazard detection.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NUM_RD, 2, number of read ports (>=1)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes
- DBG_IDX0, 2, index of register shown on dbg0
- DBG_IDX1, 4, index of register shown on dbg1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- rd_en  in  1  capture enable for all read ports
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port p uses bits [p*DATA_W +: DATA_W]
- rd_valid  out  1  high the cycle after an accepted read
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- dbg0  out  DATA_W  combinational view of storage[DBG_IDX0]
- dbg1  out  DATA_W  combinational view of storage[DBG_IDX1]
- iss_en  in  1  scoreboard: mark iss_addr busy
- iss_addr  in  ADDR_W  scoreboard: register being issued
- rd_busy  out  NUM_RD  scoreboard: registered busy flag per read port

Behaviour:
- Reset: on a rst edge all entries become 0; rd_data, rd_valid and rd_busy become 0; all busy bits clear.
- rst overrides any wr_en, rd_en or iss_en in the same cycle.
- Write: at the edge where wr_en=1 and rst=0, storage[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
  - Writes are level-qualified by wr_en at clk. There is no regWrite-edge triggering.
- Read: latency 1.
  - At an edge with rd_en=1, each port captures the entry at rd_addr[p] into rd_data[p], and rd_valid <= 1.
  - If rd_en=0, rd_data holds its previous value and rd_valid <= 0.
- Bypass: if wr_en=1 at the same edge, wr_addr equals rd_addr[p], and the write is not dropped, rd_data[p] captures wr_data (write-first).
  - Multiple ports reading the same address all get the same value.
- Zero register: with ZERO_REG=1, reads of address 0 return 0 regardless of any concurrent write.
- Debug taps: dbg0 and dbg1 reflect storage contents after the edge, i.e. an update is visible in the cycle following the write.
- Address range: full 2^ADDR_W depth is usable, including the top index. No out-of-range case exists.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined:
  - One busy bit per register.
  - iss_en=1 sets busy[iss_addr]. A write with wr_en=1 clears busy[wr_addr].
  - Same register set and cleared at the same edge: set wins, because it is a newer producer.
  - Register 0 is never busy when ZERO_REG=1.
  - rd_busy[p] is captured with rd_data when rd_en=1 and holds otherwise. It reflects busy state after that edge's set/clear.
- Undefined:
  - Ports remain present; iss_en and iss_addr are ignored and rd_busy is constant 0.
  - No busy storage is synthesised.

Test Plan:
- rst=1 one cycle, then rd_en=1 for addresses 0..31 on both ports -> every rd_data=0, rd_valid=1 from the cycle after the first read; dbg0=dbg1=0.
- Write 0xDEADBEEF to r5, next cycle read r5 on port0 and r31 on port1 (r31 previously written 0x1) -> rd_data port0=0xDEADBEEF, port1=0x00000001.
- Same edge: wr_en, addr 7, data 0x12345678, with rd_en and rd_addr both ports=7 -> both ports=0x12345678 (bypass).
- wr_en addr 0 data 0xFFFFFFFF, same-edge and next-cycle reads of r0 -> 0 both times. Write 0xA5 to r2 and 0x5A to r4 -> dbg0=0xA5, dbg1=0x5A one cycle later.
- wr_en to r3 (0x77) together with rst=1, then read r3 -> 0; rd_en=0 for 3 cycles after a read -> rd_data unchanged, rd_valid=0.
- REGFILE_SCOREBOARD_EN: iss r9, read r9 -> rd_busy=1; iss r9 and write r9 same edge -> still busy; write r9 alone -> next read rd_busy=0. Without the macro, the same stimulus gives rd_busy=0 throughout.
